// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: CCE-local types, including the microcode loader FSM states.
package bp_cce_pkg;
  typedef enum logic [2:0] {
    e_ld_idle,
    e_ld_write,
    e_ld_verify,
    e_ld_check,
    e_ld_done,
    e_ld_error
  } bp_cce_ucode_loader_state_e;
endpackage

// File: rtl/bp_common_pkg.sv
// bp_common_pkg: types shared across BlackParrot blocks.
package bp_common_pkg;
  typedef enum logic [1:0] {
    e_cce_mode_uncached = 2'b00,
    e_cce_mode_normal   = 2'b01
  } bp_cce_mode_e;
endpackage

// File: rtl/bp_cce_ucode_loader.sv
// bp_cce_ucode_loader: streams microcode into the CCE instruction RAM, reads it back
// and compares additive checksums before releasing the CCE into normal mode.
module bp_cce_ucode_loader
  import bp_common_pkg::*;
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p    = 8,
  parameter int cce_instr_width_p = 48,
  parameter int num_instr_p       = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic [cce_instr_width_p-1:0] ucode_data_i,
  input  logic                         ucode_v_i,
  output logic                         ucode_ready_o,
  output logic                         ram_v_o,
  output logic                         ram_w_o,
  output logic [cce_pc_width_p-1:0]    ram_addr_o,
  output logic [cce_instr_width_p-1:0] ram_data_o,
  input  logic [cce_instr_width_p-1:0] ram_data_i,
  output bp_cce_mode_e                 cce_mode_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);
  localparam logic [cce_pc_width_p-1:0] last_addr = cce_pc_width_p'(num_instr_p - 1);
  bp_cce_ucode_loader_state_e state_q, state_d;
  logic [cce_pc_width_p-1:0]    cnt_q, cnt_d;
  logic [cce_instr_width_p-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
  logic                         rv_q, rv_d;
  logic                         last;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= e_ld_idle;
      cnt_q   <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      rv_q    <= rv_d;
    end
  assign last = cnt_q == last_addr;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wsum_d        = wsum_q;
    // read data returns one cycle after issue; fold it in whenever a read is in flight
    rsum_d        = rv_q ? rsum_q + ram_data_i : rsum_q;
    rv_d          = 1'b0;
    ucode_ready_o = 1'b0;
    ram_v_o       = 1'b0;
    ram_w_o       = 1'b0;
    ram_addr_o    = '0;
    ram_data_o    = '0;
    case (state_q)
      e_ld_write: begin
        ucode_ready_o = 1'b1;
        if (ucode_v_i) begin
          ram_v_o    = 1'b1;
          ram_w_o    = 1'b1;
          ram_addr_o = cnt_q;
          ram_data_o = ucode_data_i;
          wsum_d     = wsum_q + ucode_data_i;
          cnt_d      = last ? '0 : cnt_q + 1'b1;
          state_d    = last ? e_ld_verify : e_ld_write;
        end
      end
      e_ld_verify: begin
        ram_v_o    = 1'b1;
        ram_addr_o = cnt_q;
        rv_d       = 1'b1;
        cnt_d      = last ? '0 : cnt_q + 1'b1;
        state_d    = last ? e_ld_check : e_ld_verify;
      end
      e_ld_check: state_d = (rsum_d == wsum_q) ? e_ld_done : e_ld_error;
      default:
        if (start_i) begin
          state_d = e_ld_write;
          cnt_d   = '0;
          wsum_d  = '0;
          rsum_d  = '0;
        end
    endcase
  end
  assign busy_o     = state_q inside {e_ld_write, e_ld_verify, e_ld_check};
  assign done_o     = state_q == e_ld_done;
  assign error_o    = state_q == e_ld_error;
  assign cce_mode_o = done_o ? e_cce_mode_normal : e_cce_mode_uncached;
endmodule

// File: tb/tb_bp_cce_ucode_loader.sv
// tb_bp_cce_ucode_loader: directed sessions against a behavioural instruction RAM.
module tb_bp_cce_ucode_loader;
  import bp_common_pkg::*;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [47:0]  ucode_data_i = '0;
  logic         ucode_v_i = 1'b0;
  logic         ucode_ready_o, ram_v_o, ram_w_o, busy_o, done_o, error_o;
  logic [7:0]   ram_addr_o;
  logic [47:0]  ram_data_o;
  logic [47:0]  ram_data_i = '0;
  bp_cce_mode_e cce_mode_o;
  logic [47:0]  mem [256];
  logic [47:0]  words [8];
  bit           corrupt = 1'b0;
  int           checks = 0, errors = 0;

  bp_cce_ucode_loader #(.cce_pc_width_p(8), .cce_instr_width_p(48), .num_instr_p(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_i),
    .ucode_data_i(ucode_data_i), .ucode_v_i(ucode_v_i), .ucode_ready_o(ucode_ready_o),
    .ram_v_o(ram_v_o), .ram_w_o(ram_w_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .cce_mode_o(cce_mode_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_v_o && ram_w_o) mem[ram_addr_o] <= ram_data_o;
    if (ram_v_o && !ram_w_o) ram_data_i <= mem[ram_addr_o] ^ {47'b0, corrupt && ram_addr_o == 8'd3};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {ucode_ready_o, ram_v_o, ram_w_o, busy_o, done_o, error_o}, 0);
    chk({tag, "_addr"}, ram_addr_o, 0);
    chk({tag, "_data"}, ram_data_o, 0);
    chk({tag, "_mode"}, cce_mode_o, e_cce_mode_uncached);
  endtask

  task automatic session(input bit rnd, input int start_at, input int rst_at, input bit exp_err);
    int idx = 0, cyc = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1 chk("busy_wr", busy_o, 1);
    while (idx < 8 && cyc < 200) begin
      ucode_v_i    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ucode_data_i = words[idx];
      start_i      = (idx == start_at) && ucode_v_i;
      #1;
      chk("wr_rdy", ucode_ready_o, 1);
      if (ucode_v_i) begin
        chk("wr_vw", {ram_v_o, ram_w_o}, 2'b11);
        chk("wr_addr", ram_addr_o, idx);
        chk("wr_data", ram_data_o, words[idx]);
        idx++;
      end else chk("wr_idle", ram_v_o, 0);
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
    end
    ucode_v_i = 1'b0;
    chk("wr_count", idx, 8);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rd_vw", {ram_v_o, ram_w_o}, 2'b10);
      chk("rd_addr", ram_addr_o, k);
      @(negedge clk);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    #1;
    chk("chk_busy", {busy_o, ram_v_o, done_o, error_o}, 4'b1000);
    @(negedge clk);
    #1;
    chk("end_flags", {busy_o, done_o, error_o}, {1'b0, !exp_err, exp_err});
    chk("end_mode", cce_mode_o, exp_err ? e_cce_mode_uncached : e_cce_mode_normal);
  endtask

  initial begin
    #2 chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk_reset_vals("idle");
    for (int i = 0; i < 8; i++) words[i] = 48'(i + 1);
    session(1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 8; i++) words[i] = {16'h5a00 + 16'(i), 32'hdead_0000 + 32'(i * 17)};
    session(1'b1, -1, -1, 1'b0);
    corrupt = 1'b1;
    session(1'b0, -1, -1, 1'b1);
    corrupt = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = 48'hFFFF_FFFF_FFFF;
    session(1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 8; i++) words[i] = 48'(32'h1000 * (i + 3));
    session(1'b0, -1, 4, 1'b0);
    #1 chk_reset_vals("post_rst");
    session(1'b0, -1, -1, 1'b0);
    session(1'b0, 5, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_cce_ucode_loader.md
BP_CCE_UCODE_LOADER -- requirements
Module: bp_cce_ucode_loader

Interface
REQ-001 Parameters SHALL be: cce_pc_width_p, default 8, instruction RAM address width; cce_instr_width_p, default 48, microcode word width; num_instr_p, default 256, words loaded per session, 1..2^cce_pc_width_p.
REQ-002 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_n_i  in  1  reset; asynchronous, active-low.
REQ-004 start_i  in  1  one-cycle pulse that begins a load session.
REQ-005 ucode_data_i  in  cce_instr_width_p  microcode word from the loader stream.
REQ-006 ucode_v_i  in  1  ucode_data_i is valid.
REQ-007 ucode_ready_o  out  1  loader accepts a word this cycle.
REQ-008 ram_v_o  out  1  instruction RAM access enable.
REQ-009 ram_w_o  out  1  RAM write (1) or read (0).
REQ-010 ram_addr_o  out  cce_pc_width_p  RAM address.
REQ-011 ram_data_o  out  cce_instr_width_p  RAM write data.
REQ-012 ram_data_i  in  cce_instr_width_p  RAM read data, valid one cycle after a read is issued.
REQ-013 cce_mode_o  out  bp_cce_mode_e  e_cce_mode_uncached until load verified, then e_cce_mode_normal.
REQ-014 busy_o  out  1  session in progress (WRITE, VERIFY or CHECK).
REQ-015 done_o  out  1  level; last session passed verify.
REQ-016 error_o  out  1  level; last session failed verify.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, VERIFY, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR on start_i SHALL go to WRITE, clear the address counter and checksum, and drive cce_mode_o uncached.
REQ-019 start_i in WRITE, VERIFY or CHECK SHALL be ignored.
REQ-020 ucode_ready_o SHALL be 1 only in WRITE and SHALL NOT depend combinationally on ucode_v_i.
REQ-021 A write SHALL occur on a cycle with ucode_v_i & ucode_ready_o: ram_v_o=1, ram_w_o=1, ram_addr_o=counter, ram_data_o=ucode_data_i; the counter increments and the checksum adds ucode_data_i.
REQ-022 Checksum SHALL be a modulo-2^cce_instr_width_p sum; carries are discarded.
REQ-023 On the write at address num_instr_p-1, the FSM SHALL go to VERIFY with the counter cleared; the counter SHALL NOT wrap within a session.
REQ-024 VERIFY SHALL issue one read per cycle (ram_v_o=1, ram_w_o=0) for addresses 0..num_instr_p-1 back-to-back, with no stall.
REQ-025 A one-bit read-valid register SHALL track each issued read; on the following cycle ram_data_i is added into a separate readback sum.
REQ-026 After the read at num_instr_p-1, the FSM SHALL go to CHECK, absorb the final read data, and compare the sums.
REQ-027 CHECK SHALL go to DONE on equal sums, otherwise to ERROR.
REQ-028 DONE SHALL set done_o=1, error_o=0 and cce_mode_o normal; ERROR SHALL set error_o=1, done_o=0 and leave the mode uncached.
REQ-029 Outside WRITE/VERIFY, ram_v_o, ram_w_o, ram_addr_o and ram_data_o SHALL be 0.
REQ-030 Latency SHALL be, from start_i: N stream handshakes, then N VERIFY cycles, then 1 CHECK cycle, with done_o asserted the next cycle, for N=num_instr_p.
REQ-031 num_instr_p=1 SHALL work: one write, one read, then CHECK.

Reset
REQ-032 Asserting reset_n_i at any time, including mid-session, SHALL asynchronously force IDLE, counter=0, both sums=0, read-valid=0, with no partial session resumed.
REQ-033 Reset values SHALL be: ucode_ready_o=0, ram_v_o=0, ram_w_o=0, ram_addr_o=0, ram_data_o=0, busy_o=0, done_o=0, error_o=0, cce_mode_o=e_cce_mode_uncached.

Structure
REQ-034 The loader state enum bp_cce_ucode_loader_state_e SHALL live in bp_cce_pkg; bp_cce_mode_e SHALL be reused from bp_common_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the counter and sums are local registers.

Verification (num_instr_p=8, cce_instr_width_p=48)
REQ-036 Happy path: start, stream words 1..8 with v_i always high -> 8 RAM writes at addr 0..7, 8 reads, done_o=1 and mode normal 17 cycles after the first handshake.
REQ-037 Backpressure: ucode_v_i random 50% duty -> writes only on handshakes, addresses contiguous, done_o=1.
REQ-038 Corruption: bench RAM model flips bit 0 of addr 3 on readback -> error_o=1, mode stays uncached.
REQ-039 Wrap: words 0xFFFF_FFFF_FFFF x8 -> checksum discards carries, done_o=1.
REQ-040 Reset mid-VERIFY after the read at addr 4 -> IDLE, all outputs at reset values; new start -> full clean session ending in done_o=1.
REQ-041 start_i pulsed during WRITE at addr 5 -> ignored, session completes normally.
